// File: rtl/mux_pkg.sv
// Shared definitions for the registered word multiplexer: parameter limits
// and bus-width helpers used by both the top module and the word selector.
package mux_pkg;

  localparam int MAX_SELECT_LINES = 8;
  localparam int MAX_DATA_WIDTH   = 256;

  function automatic int mux_word_count(input int select_lines);
    return 2 ** select_lines;
  endfunction

  function automatic int mux_bus_width(input int select_lines, input int data_width);
    return data_width * mux_word_count(select_lines);
  endfunction

endpackage

// File: rtl/mux_word_select.sv
// Purely combinational lane picker: forwards word `select_i` of a packed bus,
// word 0 in the LSBs. An X on the index propagates as X on the output.
module mux_word_select
  import mux_pkg::*;
#(
  parameter int SELECT_LINES = 4,
  parameter int DATA_WIDTH   = 2
) (
  input  logic [SELECT_LINES-1:0]                              select_i,
  input  logic [mux_bus_width(SELECT_LINES, DATA_WIDTH)-1:0]   data_i,
  output logic [DATA_WIDTH-1:0]                                word_o
);

  // The index space is fully populated, so no out-of-range default is needed.
  assign word_o = data_i[select_i*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/registered_mux.sv
// N-to-1 word multiplexer with a zero-latency combinational output and a
// registered copy that carries a valid flag for pipelined datapaths.
module registered_mux
  import mux_pkg::*;
#(
  parameter int SELECT_LINES = 4,
  parameter int DATA_WIDTH   = 2
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               en,
  input  logic [SELECT_LINES-1:0]                            select,
  input  logic [mux_bus_width(SELECT_LINES, DATA_WIDTH)-1:0] data_in,
  output logic [DATA_WIDTH-1:0]                              data_out_comb,
  output logic [DATA_WIDTH-1:0]                              data_out,
  output logic                                               valid_out
);

  if (SELECT_LINES < 1 || SELECT_LINES > MAX_SELECT_LINES) begin : g_bad_select_lines
    $error("registered_mux: SELECT_LINES=%0d outside 1..%0d", SELECT_LINES, MAX_SELECT_LINES);
  end

  if (DATA_WIDTH < 1 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_data_width
    $error("registered_mux: DATA_WIDTH=%0d outside 1..%0d", DATA_WIDTH, MAX_DATA_WIDTH);
  end

  logic [DATA_WIDTH-1:0] selWord;
  logic [DATA_WIDTH-1:0] dataOut_d;
  logic [DATA_WIDTH-1:0] dataOut_q;
  logic                  valid_d;
  logic                  valid_q;

  mux_word_select #(
    .SELECT_LINES(SELECT_LINES),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_word_select (
    .select_i(select),
    .data_i  (data_in),
    .word_o  (selWord)
  );

  assign data_out_comb = selWord;

  // Valid only reflects whether the previous edge captured; data holds otherwise.
  always_comb begin
    dataOut_d = dataOut_q;
    valid_d   = en;
    if (en) begin
      dataOut_d = selWord;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataOut_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      dataOut_q <= dataOut_d;
      valid_q   <= valid_d;
    end
  end

  assign data_out  = dataOut_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_registered_mux.sv
// Randomised and directed bench for registered_mux at the default parameters
// and at the SELECT_LINES=1, DATA_WIDTH=8 corner, against a shift-and-mask model.
module tb_registered_mux;
  import mux_pkg::*;

  localparam int SL   = 4;
  localparam int DW   = 2;
  localparam int BW   = mux_bus_width(SL, DW);
  localparam int SL_S = 1;
  localparam int DW_S = 8;
  localparam int BW_S = mux_bus_width(SL_S, DW_S);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [SL-1:0]   select;
  logic [BW-1:0]   dataIn;
  logic [DW-1:0]   dataOutComb;
  logic [DW-1:0]   dataOut;
  logic            validOut;

  logic [SL_S-1:0] selectS;
  logic [BW_S-1:0] dataInS;
  logic [DW_S-1:0] dataOutCombS;
  logic [DW_S-1:0] dataOutS;
  logic            validOutS;

  logic [31:0] expOut;
  logic        expValid;
  logic [31:0] expOutS;
  logic        expValidS;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  registered_mux #(.SELECT_LINES(SL), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .select       (select),
    .data_in      (dataIn),
    .data_out_comb(dataOutComb),
    .data_out     (dataOut),
    .valid_out    (validOut)
  );

  registered_mux #(.SELECT_LINES(SL_S), .DATA_WIDTH(DW_S)) dutSmall (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .select       (selectS),
    .data_in      (dataInS),
    .data_out_comb(dataOutCombS),
    .data_out     (dataOutS),
    .valid_out    (validOutS)
  );

  // Word k of a packed bus is simply the bus shifted down by k words and masked.
  function automatic logic [31:0] refWord(input logic [63:0] bus, input int sel, input int dw);
    logic [63:0] shifted;
    shifted = bus >> (sel * dw);
    return 32'(shifted & ((64'd1 << dw) - 64'd1));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit e, input int sel, input logic [BW-1:0] d,
                               input int selS, input logic [BW_S-1:0] dS);
    @(negedge clk);
    en      = e;
    select  = SL'(sel);
    dataIn  = d;
    selectS = SL_S'(selS);
    dataInS = dS;
    #1;
  endtask

  task automatic checkComb(input string tag);
    checkOutput({tag, "_comb"}, 32'(dataOutComb), refWord(64'(dataIn), int'(select), DW));
    checkOutput({tag, "_combS"}, 32'(dataOutCombS), refWord(64'(dataInS), int'(selectS), DW_S));
  endtask

  task automatic clockEdge(input string tag);
    @(posedge clk);
    if (rst_n) begin
      expValid  = en;
      expValidS = en;
      if (en) begin
        expOut  = refWord(64'(dataIn), int'(select), DW);
        expOutS = refWord(64'(dataInS), int'(selectS), DW_S);
      end
    end
    #1;
    checkOutput({tag, "_reg"}, 32'(dataOut), expOut);
    checkOutput({tag, "_valid"}, 32'(validOut), 32'(expValid));
    checkOutput({tag, "_regS"}, 32'(dataOutS), expOutS);
    checkOutput({tag, "_validS"}, 32'(validOutS), 32'(expValidS));
  endtask

  task automatic pulseReset(input string tag);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    expOut = '0; expValid = 1'b0; expOutS = '0; expValidS = 1'b0;
    checkOutput({tag, "_rstOut"}, 32'(dataOut), 32'd0);
    checkOutput({tag, "_rstValid"}, 32'(validOut), 32'd0);
    checkOutput({tag, "_rstOutS"}, 32'(dataOutS), 32'd0);
    checkOutput({tag, "_rstValidS"}, 32'(validOutS), 32'd0);
    checkComb({tag, "_rst"});
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    select  = SL'(3);
    dataIn  = 32'hE4E4_E4E4;
    selectS = 1'b0;
    dataInS = 16'hA55A;
    expOut = '0; expValid = 1'b0; expOutS = '0; expValidS = 1'b0;

    // Reset held with en=1 and live data: registers stay clear, comb path still works.
    clockEdge("reset_hold");
    clockEdge("reset_hold2");
    checkOutput("reset_dataOut", 32'(dataOut), 32'd0);
    checkOutput("reset_valid", 32'(validOut), 32'd0);
    checkOutput("reset_comb", 32'(dataOutComb), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    clockEdge("first_capture");
    checkOutput("first_valid", 32'(validOut), 32'd1);
    checkOutput("first_data", 32'(dataOut), 32'd3);

    // Sweep over 0x155: words 0..4 are 01, the rest 00.
    for (int s = 0; s < 16; s++) begin
      applyStimulus(1'b1, s, 32'h0000_0155, s % 2, 16'hA55A);
      checkOutput("sweep_comb", 32'(dataOutComb), (s <= 4) ? 32'd1 : 32'd0);
      clockEdge("sweep");
      checkOutput("sweep_data", 32'(dataOut), (s <= 4) ? 32'd1 : 32'd0);
    end

    // Lane isolation, then word 7 flipped from 3 to 0.
    for (int s = 0; s < 16; s++) begin
      applyStimulus(1'b1, s, 32'hE4E4_E4E4, 0, 16'hA55A);
      checkOutput("lane_comb", 32'(dataOutComb), 32'(s % 4));
      clockEdge("lane");
    end
    for (int s = 0; s < 16; s++) begin
      applyStimulus(1'b1, s, 32'hE4E4_24E4, 1, 16'hA55A);
      checkOutput("lane7_comb", 32'(dataOutComb), (s == 7) ? 32'd0 : 32'(s % 4));
      clockEdge("lane7");
    end

    // Enable hold.
    applyStimulus(1'b1, 2, 32'hE4E4_E4E4, 0, 16'hA55A);
    clockEdge("hold_capture");
    checkOutput("hold_capture", 32'(dataOut), 32'd2);
    applyStimulus(1'b0, 5, 32'hE4E4_E4E4, 1, 16'hA55A);
    checkOutput("hold_comb", 32'(dataOutComb), 32'd1);
    clockEdge("hold");
    checkOutput("hold_data", 32'(dataOut), 32'd2);
    checkOutput("hold_valid", 32'(validOut), 32'd0);

    // Asynchronous reset between edges while holding 2'b11.
    applyStimulus(1'b1, 3, 32'hE4E4_E4E4, 1, 16'hA55A);
    clockEdge("pre_async");
    checkOutput("pre_async_data", 32'(dataOut), 32'd3);
    pulseReset("async");
    clockEdge("post_async");

    // Parameter corner on the small instance.
    applyStimulus(1'b1, 0, 32'h0, 0, 16'hA55A);
    checkOutput("corner_sel0_comb", 32'(dataOutCombS), 32'h5A);
    clockEdge("corner_sel0");
    checkOutput("corner_sel0_reg", 32'(dataOutS), 32'h5A);
    applyStimulus(1'b1, 0, 32'h0, 1, 16'hA55A);
    checkOutput("corner_sel1_comb", 32'(dataOutCombS), 32'hA5);
    clockEdge("corner_sel1");
    checkOutput("corner_sel1_reg", 32'(dataOutS), 32'hA5);

    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), $urandom,
                    int'($urandom_range(0, 1)), 16'($urandom));
      checkComb("rand");
      if (i % 50 == 25) begin
        pulseReset("rand");
      end
      clockEdge("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/registered_mux.md
Name: registered_mux

Overview:
- Parameterised N-to-1 word multiplexer with `2**SELECT_LINES` inputs of `DATA_WIDTH` bits each, packed into one flat bus.
- Provides two outputs:
  - a combinational selected word;
  - a registered copy with a valid flag, for use in pipelined datapaths.
- Used as a generic building block wherever one lane of a packed bus is picked by an index.

Parameters:
- SELECT_LINES, 4, width of select index; number of input words = `2**SELECT_LINES`; legal range 1..8.
- DATA_WIDTH, 2, width of each input word and of the outputs; legal range 1..256.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable for the registered path.
- select  input  SELECT_LINES  index of the word to forward.
- data_in  input  `DATA_WIDTH*2**SELECT_LINES`  packed input words; word k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`, word 0 in the LSBs.
- data_out_comb  output  DATA_WIDTH  combinational selected word.
- data_out  output  DATA_WIDTH  registered selected word.
- valid_out  output  1  high when data_out holds a word captured on the previous enabled cycle.

Behaviour:
- Combinational path:
  - `data_out_comb = data_in[select*DATA_WIDTH +: DATA_WIDTH]` at all times, zero latency, no clock involvement.
  - Reset does not affect data_out_comb.
- Registered path, on each rising clk edge with rst_n high:
  - If en=1: data_out <= data_out_comb; valid_out <= 1.
  - If en=0: data_out holds its value; valid_out <= 0.
- Latency: a select/data_in change with en=1 appears on data_out exactly one cycle later.
- Reset:
  - rst_n low asynchronously forces data_out=0 and valid_out=0, independent of clk.
  - Outputs stay at 0 while rst_n is low.
  - The first capture occurs on the first rising edge after rst_n deasserts with en=1.
- Reset asserted mid-operation: the registered value is discarded immediately; no partial update.
- Boundaries:
  - select=0 picks the LSB word; `select=2**SELECT_LINES-1` picks the MSB word.
  - Every select value is legal because the index space is fully populated; no out-of-range case exists.
- X handling: X bits on select propagate as X to data_out_comb in simulation; no default substitution.
- No internal state other than the data_out and valid_out registers.

Decomposition:
- Shared package `mux_pkg`:
  - function `mux_bus_width(select_lines, data_width)` returning `data_width * 2**select_lines`;
  - localparam limits MAX_SELECT_LINES=8 and MAX_DATA_WIDTH=256, checked by elaboration-time assertions in the top module.
- Sub-module `mux_word_select`:
  - purely combinational indexed part-select producing data_out_comb;
  - instantiated once.
- The top module adds the output register, enable and valid logic.

Test Plan:
- Reset: hold rst_n=0 with en=1, select=3, data_in=non-zero -> data_out=0, valid_out=0. Deassert rst_n, then one clk edge -> valid_out=1.
- Sweep (defaults SELECT_LINES=4, DATA_WIDTH=2):
  - data_in=`32'h0000_0155` (binary ...0101010101); step select 0..15 with en=1.
  - Required data_out_comb = 2'b01 for select 0..4 and 2'b00 for select 5..15.
  - data_out matches each of these one cycle later.
- Lane isolation: data_in with word k = k mod 4 (value `32'hE4E4_E4E4`); sweep select 0..15 -> data_out_comb = select mod 4. Then toggle only word 7 -> output changes only when select=7.
- Enable hold: capture select=2 (data_out=2'b10 from the lane-isolation data), then en=0 and change select to 5 -> data_out stays 2'b10, valid_out=0 from the next edge, data_out_comb=2'b01 immediately.
- Async reset mid-stream: while data_out=2'b11, pulse rst_n low between clock edges -> data_out=0 and valid_out=0 immediately, without waiting for clk.
- Parameter corner: SELECT_LINES=1, DATA_WIDTH=8, data_in=`16'hA55A` -> select=0 gives 8'h5A, select=1 gives 8'hA5.
